// File: rtl/servo_pwm_multi.sv
// servo_pwm_multi: multi-channel hobby-servo PWM generator.
//
// Each channel outputs one pulse per frame. The pulse is MIN_CYC + pos*STEP_CYC
// clocks wide. Positions come from one of four sources:
//   00 hold, 01 triangle sweep, 10 sine table, 11 direct write.
// A channel's applied position is taken from its target only at the start of
// a frame, so a pulse never changes width in the middle of a frame.
//
// Optional feature: define SERVO_SINE_MODE_EN to build the sine ROM and the
// mode 10 behaviour. Without the macro, mode 10 holds the targets (as mode 00).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   en         1 enables pulses; 0 forces servo outputs low (state keeps running)
//   mode[1:0]  position source select
//   pos_in     direct positions, channel k at [k*RES +: RES]
//   pos_we     per-channel write strobe for pos_in (mode 11 only)
//   servo      PWM output per channel (registered)
//   frame_tick one-cycle pulse for the frame_cnt==0 cycle (registered)
//   pos_out    applied position per channel, channel k at [k*RES +: RES]
module servo_pwm_multi #(
    parameter int NCH        = 4,
    parameter int RES        = 8,
    parameter int FRAME_CYC  = 2500000,
    parameter int MIN_CYC    = 125000,
    parameter int STEP_CYC   = 490,
    parameter int UPD_FRAMES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [NCH*RES-1:0] pos_in,
    input  logic [NCH-1:0]     pos_we,
    output logic [NCH-1:0]     servo,
    output logic               frame_tick,
    output logic [NCH*RES-1:0] pos_out
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_SWEEP  = 2'b01,
        MODE_SINE   = 2'b10,
        MODE_DIRECT = 2'b11
    } mode_e;

    localparam int unsigned SPACING = (2 ** RES) / NCH;

    function automatic logic [RES-1:0] stagger(input int unsigned k);
        return RES'(k * SPACING);
    endfunction

    logic [31:0]    frame_cnt;
    logic [31:0]    div_cnt;
    logic [RES-1:0] target   [NCH];
    logic [RES-1:0] applied  [NCH];
    logic [RES-1:0] phase    [NCH];
    logic           dir_down [NCH];
    logic [RES-1:0] applied_nxt [NCH];
    logic [31:0]    width    [NCH];
    logic           frame_start;
    logic           upd;
    mode_e          mode_sel;

    assign mode_sel    = mode_e'(mode);
    assign frame_start = (frame_cnt == '0);
    assign upd         = frame_start && (div_cnt == '0);

`ifdef SERVO_SINE_MODE_EN
    localparam real PI = 3.14159265358979323846;

    function automatic logic [RES-1:0] sin_val(input int unsigned i);
        real a;
        a = (1.0 + $sin(2.0 * PI * real'(i) / real'(2 ** RES)))
            * real'((2 ** RES) - 1) / 2.0;
        return RES'($rtoi($floor(a)));
    endfunction

    logic [RES-1:0] sin_rom [2**RES];

    // Constant contents; folds to a ROM at synthesis.
    always_comb begin
        for (int unsigned i = 0; i < 2 ** RES; i++) begin
            sin_rom[i] = sin_val(i);
        end
    end
`endif

    // The frame_cnt==0 cycle compares against the position being loaded, so the
    // output is consistent with the applied value for the whole frame.
    always_comb begin
        for (int unsigned k = 0; k < NCH; k++) begin
            applied_nxt[k] = frame_start ? target[k] : applied[k];
            width[k] = 32'(MIN_CYC) + 32'(applied_nxt[k]) * 32'(STEP_CYC);
        end
    end

    always_comb begin
        pos_out = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            pos_out[k*RES +: RES] = applied[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt  <= '0;
            div_cnt    <= '0;
            frame_tick <= 1'b0;
            servo      <= '0;
            for (int unsigned k = 0; k < NCH; k++) begin
                target[k]   <= stagger(k);
                applied[k]  <= stagger(k);
                phase[k]    <= stagger(k);
                dir_down[k] <= 1'b0;
            end
        end else begin
            frame_cnt  <= (frame_cnt == 32'(FRAME_CYC - 1)) ? '0 : frame_cnt + 32'd1;
            frame_tick <= frame_start;
            if (frame_start) begin
                div_cnt <= (div_cnt == 32'(UPD_FRAMES - 1)) ? '0 : div_cnt + 32'd1;
            end
            for (int unsigned k = 0; k < NCH; k++) begin
                servo[k]   <= en && (frame_cnt < width[k]);
                applied[k] <= applied_nxt[k];
                case (mode_sel)
                    MODE_DIRECT: begin
                        if (pos_we[k]) begin
                            target[k] <= pos_in[k*RES +: RES];
                        end
                    end
                    MODE_SWEEP: begin
                        // Endpoints turn around immediately, so each end value
                        // is occupied for a single step.
                        if (upd) begin
                            if (!dir_down[k]) begin
                                if (target[k] == '1) begin
                                    target[k]   <= target[k] - RES'(1);
                                    dir_down[k] <= 1'b1;
                                end else begin
                                    target[k] <= target[k] + RES'(1);
                                end
                            end else begin
                                if (target[k] == '0) begin
                                    target[k]   <= RES'(1);
                                    dir_down[k] <= 1'b0;
                                end else begin
                                    target[k] <= target[k] - RES'(1);
                                end
                            end
                        end
                    end
                    MODE_SINE: begin
`ifdef SERVO_SINE_MODE_EN
                        if (upd) begin
                            phase[k]  <= phase[k] + RES'(1);
                            target[k] <= sin_rom[phase[k] + RES'(1)];
                        end
`endif
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_multi.sv
module tb_servo_pwm_multi;
    localparam int NCH   = 2;
    localparam int RES   = 4;
    localparam int FRAME = 1000;
    localparam int MINC  = 100;
    localparam int STEPC = 2;
    localparam int UPD   = 1;
    localparam int PM    = (1 << RES) - 1;
    localparam int SPC   = (1 << RES) / NCH;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic [1:0]         mode = 2'b00;
    logic [NCH*RES-1:0] pos_in = '0;
    logic [NCH-1:0]     pos_we = '0;
    logic [NCH-1:0]     servo;
    logic               frame_tick;
    logic [NCH*RES-1:0] pos_out;

    servo_pwm_multi #(
        .NCH(NCH), .RES(RES), .FRAME_CYC(FRAME), .MIN_CYC(MINC),
        .STEP_CYC(STEPC), .UPD_FRAMES(UPD)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .pos_in(pos_in),
        .pos_we(pos_we), .servo(servo), .frame_tick(frame_tick), .pos_out(pos_out)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sinv(input int i);
        real a;
        a = (1.0 + $sin(2.0 * 3.14159265358979323846 * i / (1 << RES))) * PM / 2.0;
        return $rtoi($floor(a));
    endfunction

    // Reference model: frame counter, per-channel target/applied/phase/direction.
    int m_cnt, m_div;
    int m_tgt [NCH];
    int m_app [NCH];
    int m_ph  [NCH];
    bit m_dn  [NCH];
    logic [NCH-1:0]     e_servo;
    logic               e_tick;
    logic [NCH*RES-1:0] e_pos;

    initial begin
        forever begin
            bit strobe;
            @(posedge clk);
            if (rst) begin
                m_cnt = 0;
                m_div = 0;
                for (int k = 0; k < NCH; k++) begin
                    m_tgt[k] = k * SPC;
                    m_app[k] = k * SPC;
                    m_ph[k]  = k * SPC;
                    m_dn[k]  = 1'b0;
                end
                e_servo = '0;
                e_tick  = 1'b0;
            end else begin
                e_tick = (m_cnt == 0);
                strobe = (m_cnt == 0) && (m_div == 0);
                if (m_cnt == 0) begin
                    for (int k = 0; k < NCH; k++) m_app[k] = m_tgt[k];
                    m_div = (m_div + 1) % UPD;
                end
                for (int k = 0; k < NCH; k++) begin
                    e_servo[k] = en && (m_cnt < MINC + m_app[k] * STEPC);
                    case (mode)
                        2'b11: if (pos_we[k]) m_tgt[k] = int'(pos_in[k*RES +: RES]);
                        2'b01: if (strobe) begin
                            if (!m_dn[k]) begin
                                if (m_tgt[k] == PM) begin m_dn[k] = 1'b1; m_tgt[k] = PM - 1; end
                                else m_tgt[k] = m_tgt[k] + 1;
                            end else begin
                                if (m_tgt[k] == 0) begin m_dn[k] = 1'b0; m_tgt[k] = 1; end
                                else m_tgt[k] = m_tgt[k] - 1;
                            end
                        end
`ifdef SERVO_SINE_MODE_EN
                        2'b10: if (strobe) begin
                            m_ph[k]  = (m_ph[k] + 1) % (PM + 1);
                            m_tgt[k] = sinv(m_ph[k]);
                        end
`endif
                        default: ;
                    endcase
                end
                m_cnt = (m_cnt + 1) % FRAME;
            end
            for (int k = 0; k < NCH; k++) e_pos[k*RES +: RES] = RES'(m_app[k]);
            #1;
            check("servo", 32'(servo), 32'(e_servo));
            check("frame_tick", 32'(frame_tick), 32'(e_tick));
            check("pos_out", 32'(pos_out), 32'(e_pos));
        end
    end

    // Advance to the next negedge on which frame_tick is high.
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_tick && n < 1100);
        if (!frame_tick) check("tick_timeout", 32'(0), 32'(1));
    endtask

    // Count high cycles per channel over one frame starting at the current negedge.
    task automatic measure(output int w0, output int w1);
        w0 = 0;
        w1 = 0;
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            w0 += int'(servo[0]);
            w1 += int'(servo[1]);
        end
    endtask

    function automatic int ch0(input logic [NCH*RES-1:0] p);
        return int'(p[RES-1:0]);
    endfunction

    initial begin
        int w0, w1, n;
        int sweep_exp [4] = '{14, 15, 14, 13};
        int sine_exp  [4];
`ifdef SERVO_SINE_MODE_EN
        sine_exp = '{10, 12, 14, 15};
`else
        sine_exp = '{0, 0, 0, 0};
`endif
        repeat (3) @(negedge clk);
        check("reset_servo", 32'(servo), 32'(0));
        check("reset_tick", 32'(frame_tick), 32'(0));
        rst = 1'b0;
        en = 1'b1;

        // Reset positions 0 and 8 -> widths 100 and 116.
        wait_tick();
        check("reset_pos", 32'(pos_out), 32'(8'h80));
        measure(w0, w1);
        check("width_ch0_pos0", 32'(w0), 32'(100));
        check("width_ch1_pos8", 32'(w1), 32'(116));
        @(negedge clk);
        check("tick_period", 32'(frame_tick), 32'(1));

        // Direct write mid-frame takes effect next frame.
        repeat (50) @(negedge clk);
        mode = 2'b11;
        pos_in = 8'h0F;
        pos_we = 2'b01;
        @(negedge clk);
        pos_we = 2'b00;
        repeat (20) @(negedge clk);
        check("direct_same_frame", 32'(ch0(pos_out)), 32'(0));
        wait_tick();
        check("direct_next_frame", 32'(ch0(pos_out)), 32'(15));
        measure(w0, w1);
        check("width_ch0_pos15", 32'(w0), 32'(130));

        // Sweep endpoint from 13.
        @(negedge clk);
        pos_in = 8'h0D;
        pos_we = 2'b01;
        @(negedge clk);
        pos_we = 2'b00;
        wait_tick();
        check("sweep_start", 32'(ch0(pos_out)), 32'(13));
        mode = 2'b01;
        wait_tick();
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            check("sweep_seq", 32'(ch0(pos_out)), 32'(sweep_exp[i]));
        end

        // Gated outputs, positions keep sweeping.
        en = 1'b0;
        wait_tick();
        check("gated_pos", 32'(ch0(pos_out)), 32'(12));
        measure(w0, w1);
        check("gated_ch0", 32'(w0), 32'(0));
        check("gated_ch1", 32'(w1), 32'(0));
        en = 1'b1;

        // Mid-frame reset, then sine (or hold) from reset state.
        wait_tick();
        repeat (49) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mode = 2'b10;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!servo[0] && n < 1100);
        check("restart_at_frame0", 32'(frame_tick), 32'(1));
        check("restart_pos", 32'(ch0(pos_out)), 32'(0));
        for (int i = 0; i < 4; i++) begin
            wait_tick();
            check("sine_seq", 32'(ch0(pos_out)), 32'(sine_exp[i]));
        end

        // Randomized operation checked cycle by cycle by the model.
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 7) != 0);
            mode = 2'($urandom_range(0, 3));
            pos_in = NCH*RES'($urandom);
            pos_we = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
            @(negedge clk);
            pos_we = '0;
            repeat ($urandom_range(20, 150)) @(negedge clk);
            if (i == 120) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
